imm_ext_unit: RTL and testbench

Parametrised, pipelined immediate extension unit for the datapath's decode stage. Accepts an immediate plus an extension opcode through a valid/ready handshake, computes sign, zero, upper-load, fixed-shift or variable-shift extension to `OUT_W` bits, and buffers results in a 2-entry output queue so decode back-pressure never drops an operand. Also reports illegal opcodes and keeps a running count of delivered results.

---
 rtl/imm_ext_unit.sv | 118 +++++++++++
 tb/tb_imm_ext_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_unit.sv
// Immediate extension unit: extends an immediate per opcode and queues the
// result (with tag and illegal-opcode flag) in a 2-entry output FIFO.
module imm_ext_unit #(
    parameter int unsigned IMM_W = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SHIFT = 2,
    parameter int unsigned TAG_W = 5,
    localparam int unsigned SH_W = $clog2(OUT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] imm,
    input  logic [2:0]       EOp,
    input  logic [SH_W-1:0]  sh,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [15:0]      done_cnt
);

    typedef struct packed {
        logic [OUT_W-1:0] ext;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] done_q, done_d;

    logic                   push, pop;
    entry_t                 new_entry;
    logic [OUT_W+IMM_W-1:0] sext_wide;
    logic [OUT_W-1:0]       sext, zext;

    // Extension datapath
    always_comb begin
        sext_wide = {{OUT_W{imm[IMM_W-1]}}, imm};
        sext      = sext_wide[OUT_W-1:0];
        zext      = OUT_W'(imm);
        new_entry = '0;
        new_entry.tag = tag;
        case (EOp)
            3'b000:  new_entry.ext = sext;
            3'b001:  new_entry.ext = zext;
            3'b010:  new_entry.ext = zext << (OUT_W - IMM_W);
            3'b011:  new_entry.ext = sext << SHIFT;
            3'b100:  new_entry.ext = sext << sh;
            default: new_entry.err = 1'b1;
        endcase
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head always lives in head_q so it simply holds its value once drained.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        done_d  = done_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                done_d = done_q + 16'd1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = new_entry;
                    end else begin
                        tail_d = new_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                    end
                    count_d = count_q - 2'd1;
                end
                // Both only possible at count 1: new entry replaces the head.
                2'b11:   head_d = new_entry;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            done_q  <= 16'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign ext      = head_q.ext;
    assign out_tag  = head_q.tag;
    assign out_err  = head_q.err;
    assign done_cnt = done_q;

endmodule

// File: tb/tb_imm_ext_unit.sv
// Self-checking bench for imm_ext_unit: queue-based reference model checked
// every cycle, plus directed literal checks and a small-parameter instance.
module tb_imm_ext_unit;

    localparam int unsigned IMM_W = 16;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned SHIFT = 2;
    localparam int unsigned TAG_W = 5;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] imm;
    logic [2:0]  EOp;
    logic [4:0]  sh;
    logic [4:0]  tag, out_tag;
    logic [31:0] ext;
    logic [15:0] done_cnt;

    logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_out_err, p_flush;
    logic [11:0] p_imm;
    logic [2:0]  p_eop;
    logic [3:0]  p_sh;
    logic [4:0]  p_tag, p_out_tag;
    logic [15:0] p_ext, p_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_ext_unit #(.IMM_W(IMM_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .EOp(EOp), .sh(sh), .tag(tag), .out_valid(out_valid),
        .out_ready(out_ready), .ext(ext), .out_tag(out_tag), .out_err(out_err),
        .done_cnt(done_cnt)
    );

    imm_ext_unit #(.IMM_W(12), .OUT_W(16), .SHIFT(1), .TAG_W(5)) u_small (
        .clk(clk), .reset(reset), .flush(p_flush), .in_valid(p_in_valid),
        .in_ready(p_in_ready), .imm(p_imm), .EOp(p_eop), .sh(p_sh), .tag(p_tag),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .ext(p_ext), .out_tag(p_out_tag),
        .out_err(p_out_err), .done_cnt(p_done)
    );

    typedef struct packed {
        logic [31:0] e;
        logic [4:0]  t;
        logic        r;
    } ent_t;

    ent_t        mq[$];
    ent_t        hold;
    logic        hold_ok;
    logic [15:0] m_cnt;

    // Reference: sign value as a plain integer, scaled by powers of two, taken mod 2^OUT_W.
    function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [2:0] op,
                                            input int unsigned s);
        longint sv;
        longint r;
        sv = i[IMM_W-1] ? longint'(i) - (longint'(1) << IMM_W) : longint'(i);
        case (op)
            3'd0:    r = sv;
            3'd1:    r = longint'(i);
            3'd2:    r = longint'(i) * (longint'(1) << (OUT_W - IMM_W));
            3'd3:    r = sv * (longint'(1) << SHIFT);
            3'd4:    r = sv * (longint'(1) << s);
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        bit acc, pp;
        ent_t n;
        if (reset) begin
            mq.delete();
            m_cnt   = 16'd0;
            hold    = '0;
            hold_ok = 1'b1;
        end else begin
            acc = in_valid && (mq.size() < 2);
            pp  = out_ready && (mq.size() > 0);
            if (mq.size() > 0) begin
                hold    = mq[0];
                hold_ok = 1'b1;
            end
            if (flush) begin
                mq.delete();
                hold_ok = 1'b0;
            end else begin
                if (pp) begin
                    void'(mq.pop_front());
                    m_cnt = m_cnt + 16'd1;
                end
                if (acc) begin
                    n.e = ref_ext(imm, EOp, int'(sh));
                    n.t = tag;
                    n.r = (EOp > 3'd4);
                    mq.push_back(n);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", 64'(in_ready), 64'(mq.size() != 2));
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("done_cnt", 64'(done_cnt), 64'(m_cnt));
            if (mq.size() != 0) begin
                chk("ext", 64'(ext), 64'(mq[0].e));
                chk("out_tag", 64'(out_tag), 64'(mq[0].t));
                chk("out_err", 64'(out_err), 64'(mq[0].r));
            end else if (hold_ok) begin
                chk("hold_ext", 64'(ext), 64'(hold.e));
                chk("hold_tag", 64'(out_tag), 64'(hold.t));
            end
        end
    end

    task automatic step(input logic iv, input logic ordy, input logic fl);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_req();
        imm = 16'($urandom);
        EOp = 3'($urandom_range(0, 7));
        sh  = 5'($urandom);
        tag = 5'($urandom);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    logic [2:0]  mode_op [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [31:0] mode_exp[6] = '{32'hFFFF8001, 32'h00008001, 32'h80010000,
                                 32'hFFFE0004, 32'hFFF80010, 32'h0};
    logic [2:0]  sw_op   [3] = '{3'd0, 3'd2, 3'd3};
    logic [15:0] sw_exp  [3] = '{16'hF800, 16'h8000, 16'hF000};
    logic [15:0] base;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        imm = '0; EOp = '0; sh = '0; tag = '0;
        p_in_valid = 1'b0; p_out_ready = 1'b0; p_flush = 1'b0;
        p_imm = '0; p_eop = '0; p_sh = '0; p_tag = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ext", 64'(ext), 64'd0);
        chk("rst_done", 64'(done_cnt), 64'd0);

        chk("pin_sext", 64'(ref_ext(16'h8001, 3'd0, 0)), 64'hFFFF8001);
        chk("pin_shl", 64'(ref_ext(16'h8001, 3'd4, 4)), 64'hFFF80010);

        for (int i = 0; i < 6; i++) begin
            imm = 16'h8001; EOp = mode_op[i]; sh = 5'd4; tag = 5'(i);
            step(1'b1, 1'b0, 1'b0);
            chk("mode_ext", 64'(ext), 64'(mode_exp[i]));
            chk("mode_err", 64'(out_err), 64'(mode_op[i] == 3'd6));
            step(1'b0, 1'b1, 1'b0);
        end

        // Back-pressure and ordering
        do_reset();
        imm = 16'h1234; EOp = 3'd0;
        tag = 5'd1; step(1'b1, 1'b0, 1'b0);
        chk("bp_ready1", 64'(in_ready), 64'd1);
        tag = 5'd2; step(1'b1, 1'b0, 1'b0);
        chk("bp_ready2", 64'(in_ready), 64'd0);
        tag = 5'd3; step(1'b1, 1'b0, 1'b0);
        chk("bp_head1", 64'(out_tag), 64'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("bp_head2", 64'(out_tag), 64'd2);
        step(1'b1, 1'b1, 1'b0);
        chk("bp_head3", 64'(out_tag), 64'd3);
        step(1'b0, 1'b1, 1'b0);
        chk("bp_done", 64'(done_cnt), 64'd3);

        // Simultaneous push/pop at count 1
        randomize_req(); step(1'b1, 1'b0, 1'b0);
        base = done_cnt;
        for (int i = 0; i < 10; i++) begin
            randomize_req(); step(1'b1, 1'b1, 1'b0);
            chk("pp_valid", 64'(out_valid), 64'd1);
            chk("pp_ready", 64'(in_ready), 64'd1);
        end
        chk("pp_done", 64'(done_cnt), 64'(base + 16'd10));

        // Flush at count 2
        randomize_req(); step(1'b1, 1'b0, 1'b0);
        base = done_cnt;
        randomize_req(); step(1'b1, 1'b1, 1'b1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        chk("fl_done", 64'(done_cnt), 64'(base));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            randomize_req();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset with a full queue
        step(1'b0, 1'b1, 1'b1);
        randomize_req(); step(1'b1, 1'b0, 1'b0);
        randomize_req(); step(1'b1, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(in_ready), 64'd1);
        chk("ar_ext", 64'(ext), 64'd0);
        chk("ar_tag", 64'(out_tag), 64'd0);
        chk("ar_err", 64'(out_err), 64'd0);
        chk("ar_done", 64'(done_cnt), 64'd0);
        #1 reset = 1'b0;

        // done_cnt wrap
        randomize_req(); step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65537; i++) begin
            randomize_req(); step(1'b1, 1'b1, 1'b0);
        end
        chk("wrap_done", 64'(done_cnt), 64'd1);

        // Small-parameter instance
        p_in_valid = 1'b1; p_out_ready = 1'b1; p_imm = 12'h800;
        for (int i = 0; i < 3; i++) begin
            p_eop = sw_op[i];
            step(1'b0, 1'b0, 1'b0);
            chk("sweep_ext", 64'(p_ext), 64'(sw_exp[i]));
            chk("sweep_err", 64'(p_out_err), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
